// File: rtl/arm_memory_responder_if.sv
// MFA/MFC memory handshake bundle between the control unit (master)
// and the memory responder (slave); signal names match the CU side.
interface arm_memory_responder_if;
  logic        MFA;
  logic        READ_WRITE;
  logic        WORD_BYTE;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Busy;

  modport master (
    output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
    input  DataOut, MFC, Busy
  );

  modport slave (
    input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
    output DataOut, MFC, Busy
  );
endinterface

// File: rtl/arm_memory_responder.sv
// Byte-addressed little-endian RAM answering the CU's four-phase MFA/MFC
// handshake after a programmable wait; read data is held until the next read.
module arm_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  arm_memory_responder_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned MEM_BYTES = 1 << ADDR_WIDTH;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic                  wb_q, wb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           dout_q, dout_d;
  logic                  mfc_q, mfc_d;

  logic [7:0]            mem [MEM_BYTES];
  logic                  mem_we;

  // Word accesses are forced onto the aligned slot, so a word never wraps
  // past the top of the RAM.
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [31:0]           word_rd;
  logic [31:0]           byte_rd;

  assign a0 = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign a1 = {addr_q[ADDR_WIDTH-1:2], 2'b01};
  assign a2 = {addr_q[ADDR_WIDTH-1:2], 2'b10};
  assign a3 = {addr_q[ADDR_WIDTH-1:2], 2'b11};

  assign word_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
  assign byte_rd = {24'b0, mem[addr_q]};

  // Upper address bits alias onto the RAM and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Address[31:ADDR_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    wb_d    = wb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.MFA) begin
          rw_d    = bus.READ_WRITE;
          wb_d    = bus.WORD_BYTE;
          addr_d  = bus.Address[ADDR_WIDTH-1:0];
          wdata_d = bus.DataIn;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mfc_d   = 1'b1;
          state_d = DONE;
          if (rw_q) begin
            dout_d = wb_q ? word_rd : byte_rd;
          end else begin
            mem_we = 1'b1;
          end
        end
      end

      DONE: begin
        if (!bus.MFA) begin
          mfc_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        mfc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      wb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      wb_q    <= wb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
    end
  end

  // RAM keeps its contents across reset; an abort in BUSY never writes
  // because reset forces state_q to IDLE and so drops mem_we.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (wb_q) begin
        mem[a0] <= wdata_q[7:0];
        mem[a1] <= wdata_q[15:8];
        mem[a2] <= wdata_q[23:16];
        mem[a3] <= wdata_q[31:24];
      end else begin
        mem[addr_q] <= wdata_q[7:0];
      end
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.MFC     = mfc_q;
  assign bus.Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_arm_memory_responder.sv
// Directed bench for arm_memory_responder: default build (WAIT_CYCLES=2)
// plus a zero-wait build sharing clock and reset.
module tb_arm_memory_responder;

  logic Clk;
  logic Reset;

  arm_memory_responder_if bus ();
  arm_memory_responder_if bus0 ();

  arm_memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  arm_memory_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One complete four-phase transaction on the default build; returns the
  // edge count from capture to MFC, the DataOut seen with MFC, and whether
  // MFC and Busy both cleared on the edge after MFA dropped.
  task automatic txn(input logic rw, input logic wb, input logic [31:0] addr,
                     input logic [31:0] data, output int lat,
                     output logic [31:0] rdata, output logic released);
    @(negedge Clk);
    bus.READ_WRITE = rw;
    bus.WORD_BYTE  = wb;
    bus.Address    = addr;
    bus.DataIn     = data;
    bus.MFA        = 1'b1;
    @(posedge Clk);
    lat = 0;
    do begin
      @(posedge Clk); #1;
      lat++;
    end while (!bus.MFC && lat < 20);
    rdata = bus.DataOut;
    @(negedge Clk);
    bus.MFA = 1'b0;
    @(posedge Clk); #1;
    released = !bus.MFC && !bus.Busy;
  endtask

  task automatic test_reset();
    logic bad;
    Reset = 1'b0;
    bus.MFA = 1'b0; bus.READ_WRITE = 1'b0; bus.WORD_BYTE = 1'b0;
    bus.Address = '0; bus.DataIn = '0;
    bus0.MFA = 1'b0; bus0.READ_WRITE = 1'b0; bus0.WORD_BYTE = 1'b0;
    bus0.Address = '0; bus0.DataIn = '0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if (bus.MFC !== 1'b0) begin n_fail++; $display("FAIL reset_mfc: got %b expected 0", bus.MFC); end
    n_checks++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    n_checks++;
    if (bus.DataOut !== 32'h0) begin n_fail++; $display("FAIL reset_dataout: got %h expected 00000000", bus.DataOut); end
    @(negedge Clk);
    Reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (bus.MFC !== 1'b0 || bus.Busy !== 1'b0 || bus.DataOut !== 32'h0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL idle_10_cycles: state moved with MFA low (got %b expected 0)", bad); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic rel;
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, rel);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL word_wr_latency: got %0d expected 3", lat); end
    n_checks++;
    if (rel !== 1'b1) begin n_fail++; $display("FAIL word_wr_release: got %b expected 1", rel); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL write_keeps_dataout: got %h expected 00000000", rd); end
    txn(1'b1, 1'b1, 32'h10, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd_0x10: got %h expected deadbeef", rd); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL word_rd_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic rel;
    txn(1'b1, 1'b0, 32'h11, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h000000BE) begin n_fail++; $display("FAIL byte_rd_0x11: got %h expected 000000be", rd); end
    txn(1'b0, 1'b0, 32'h12, 32'hAAAAAA55, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h000000BE) begin n_fail++; $display("FAIL byte_wr_holds_dataout: got %h expected 000000be", rd); end
    txn(1'b1, 1'b1, 32'h13, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL misaligned_word_rd: got %h expected de55beef", rd); end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd; logic rel;
    txn(1'b0, 1'b1, 32'h200, 32'h12345678, lat, rd, rel);
    txn(1'b1, 1'b1, 32'h000, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL alias_0x200: got %h expected 12345678", rd); end
    txn(1'b0, 1'b1, 32'h1FF, 32'hA1B2C3D4, lat, rd, rel);
    txn(1'b1, 1'b0, 32'h1FC, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h000000D4) begin n_fail++; $display("FAIL top_slot_byte0: got %h expected 000000d4", rd); end
    txn(1'b1, 1'b0, 32'h1FF, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h000000A1) begin n_fail++; $display("FAIL top_slot_byte3: got %h expected 000000a1", rd); end
    txn(1'b1, 1'b0, 32'h3FE, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h000000B2) begin n_fail++; $display("FAIL alias_byte_0x3fe: got %h expected 000000b2", rd); end
    txn(1'b1, 1'b1, 32'h000, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL top_slot_no_wrap: got %h expected 12345678", rd); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd; logic rel;
    txn(1'b0, 1'b1, 32'h20, 32'h11223344, lat, rd, rel);
    @(negedge Clk);
    bus.READ_WRITE = 1'b0; bus.WORD_BYTE = 1'b1;
    bus.Address = 32'h20; bus.DataIn = 32'hCAFEF00D; bus.MFA = 1'b1;
    @(posedge Clk); #1;
    n_checks++;
    if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL abort_captured: busy got %b expected 1", bus.Busy); end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    n_checks++;
    if (bus.MFC !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_in_busy: mfc/busy got %b%b expected 00", bus.MFC, bus.Busy);
    end
    bus.MFA = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    txn(1'b1, 1'b1, 32'h20, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h11223344) begin n_fail++; $display("FAIL abort_no_write: got %h expected 11223344", rd); end

    // Reset while in DONE: the write already landed.
    @(negedge Clk);
    bus.READ_WRITE = 1'b0; bus.WORD_BYTE = 1'b1;
    bus.Address = 32'h24; bus.DataIn = 32'h0BADF00D; bus.MFA = 1'b1;
    lat = 0;
    do begin @(posedge Clk); #1; lat++; end while (!bus.MFC && lat < 20);
    @(negedge Clk);
    Reset = 1'b0;
    bus.MFA = 1'b0;
    #1;
    n_checks++;
    if (bus.MFC !== 1'b0) begin n_fail++; $display("FAIL reset_in_done_mfc: got %b expected 0", bus.MFC); end
    @(negedge Clk);
    Reset = 1'b1;
    txn(1'b1, 1'b1, 32'h24, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL reset_in_done_persist: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_mfa_drop();
    int lat; logic [31:0] rd; logic rel; int pulses;
    @(negedge Clk);
    bus.READ_WRITE = 1'b0; bus.WORD_BYTE = 1'b1;
    bus.Address = 32'h30; bus.DataIn = 32'h600DCAFE; bus.MFA = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.MFA = 1'b0;
    bus.DataIn = 32'hFFFFFFFF;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (bus.MFC === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL mfa_drop_pulse: mfc high cycles got %0d expected 1", pulses); end
    n_checks++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL mfa_drop_idle: busy got %b expected 0", bus.Busy); end
    txn(1'b1, 1'b1, 32'h30, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'h600DCAFE) begin n_fail++; $display("FAIL mfa_drop_committed: got %h expected 600dcafe", rd); end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd; logic rel; logic bad;
    @(negedge Clk);
    bus.READ_WRITE = 1'b1; bus.WORD_BYTE = 1'b1;
    bus.Address = 32'h10; bus.DataIn = 32'h0; bus.MFA = 1'b1;
    lat = 0;
    do begin @(posedge Clk); #1; lat++; end while (!bus.MFC && lat < 20);
    @(negedge Clk);
    bus.READ_WRITE = 1'b0;
    bus.DataIn = 32'hFFFFFFFF;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      if (bus.MFC !== 1'b1 || bus.Busy !== 1'b1 || bus.DataOut !== 32'hDE55BEEF) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL hold_mfc_done: stayed-in-done violated (got %b expected 0)", bad); end
    @(negedge Clk);
    bus.MFA = 1'b0;
    @(posedge Clk); #1;
    n_checks++;
    if (bus.MFC !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: mfc/busy got %b%b expected 00", bus.MFC, bus.Busy);
    end
    txn(1'b1, 1'b1, 32'h10, 32'h0, lat, rd, rel);
    n_checks++;
    if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL hold_no_second_txn: got %h expected de55beef", rd); end
  endtask

  task automatic test_wait0();
    @(negedge Clk);
    bus0.READ_WRITE = 1'b0; bus0.WORD_BYTE = 1'b1;
    bus0.Address = 32'h40; bus0.DataIn = 32'h89ABCDEF; bus0.MFA = 1'b1;
    @(posedge Clk); #1;
    n_checks++;
    if (bus0.MFC !== 1'b0 || bus0.Busy !== 1'b1) begin
      n_fail++; $display("FAIL wait0_capture: mfc/busy got %b%b expected 01", bus0.MFC, bus0.Busy);
    end
    @(posedge Clk); #1;
    n_checks++;
    if (bus0.MFC !== 1'b1) begin n_fail++; $display("FAIL wait0_wr_latency: mfc got %b expected 1", bus0.MFC); end
    @(negedge Clk);
    bus0.MFA = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    bus0.READ_WRITE = 1'b1; bus0.MFA = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1;
    n_checks++;
    if (bus0.MFC !== 1'b1 || bus0.DataOut !== 32'h89ABCDEF) begin
      n_fail++; $display("FAIL wait0_rd: mfc %b data %h expected 1 89abcdef", bus0.MFC, bus0.DataOut);
    end
    @(negedge Clk);
    bus0.MFA = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_alias();
    test_abort();
    test_mfa_drop();
    test_hold();
    test_wait0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
